// File: rtl/rr_stream_pkg.sv
// Shared helpers for the round-robin stream multiplexer.
// Channel-index width is clamped to one bit so a single-channel build still has a legal index port.
package rr_stream_pkg;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping around.
// The request vector is doubled so the wrap-around search becomes a straight scan.
module rr_arbiter
  import rr_stream_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);

  logic [2*N_CH-1:0] w_dbl;

  assign w_dbl = {req, req};

  // Scan from farthest to nearest so the closest requester after ptr is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if ((int'(ptr) + k) < 2 * N_CH) begin
        if (w_dbl[int'(ptr) + k]) begin
          gnt_valid = 1'b1;
          gnt_idx   = ((int'(ptr) + k) >= N_CH) ? CH_W'(int'(ptr) + k - N_CH)
                                                : CH_W'(int'(ptr) + k);
        end
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration, optional packet
// locking and a single registered output stage that sustains one beat per cycle.
module rr_stream_mux
  import rr_stream_pkg::*;
#(
  parameter  int N_CH     = 4,
  parameter  int WIDTH    = 8,
  parameter  bit LOCK_PKT = 1'b1,
  localparam int CH_W     = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [CH_W-1:0]  r_ptr;
  logic             r_locked;
  logic [CH_W-1:0]  r_lock_ch;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [CH_W-1:0]  r_out_ch;

  logic             w_load;
  logic             w_lock_active;
  logic             w_arb_valid;
  logic [CH_W-1:0]  w_arb_idx;
  logic             w_gnt_valid;
  logic [CH_W-1:0]  w_gnt_idx;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_xfer;
  logic [CH_W-1:0]  w_ptr_next;

  assign w_load        = !r_out_valid || out_ready;
  assign w_lock_active = LOCK_PKT && r_locked;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req       (in_valid),
    .ptr       (r_ptr),
    .gnt_valid (w_arb_valid),
    .gnt_idx   (w_arb_idx)
  );

  // A locked channel keeps the grant even with valid low, producing bubbles rather than interleaving.
  assign w_gnt_valid = w_lock_active ? 1'b1      : w_arb_valid;
  assign w_gnt_idx   = w_lock_active ? r_lock_ch : w_arb_idx;

  always_comb begin
    in_ready    = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == w_gnt_idx) begin
        w_sel_valid = in_valid[i];
        w_sel_last  = in_last[i];
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_load && w_gnt_valid;
      end
    end
  end

  assign w_xfer     = w_load && w_gnt_valid && w_sel_valid;
  assign w_ptr_next = (w_gnt_idx == LAST_CH) ? '0 : w_gnt_idx + CH_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_locked    <= 1'b0;
      r_lock_ch   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_last  <= w_sel_last;
        r_out_ch    <= w_gnt_idx;
        if (w_sel_last || !LOCK_PKT) begin
          r_ptr <= w_ptr_next;
        end
        if (LOCK_PKT) begin
          r_locked <= !w_sel_last;
          if (!w_sel_last) begin
            r_lock_ch <= w_gnt_idx;
          end
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: three instances (per-beat 4ch, packet-locked 4ch,
// single-channel 16-bit); stimulus pushes expected beats, a forked monitor pops on each output handshake.
module tb_rr_stream_mux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_in_valid, a_in_last, a_in_ready;
  logic [31:0] a_in_data;
  logic        a_out_valid, a_out_last, a_out_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;

  logic [3:0]  b_in_valid, b_in_last, b_in_ready;
  logic [31:0] b_in_data;
  logic        b_out_valid, b_out_last, b_out_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_ch;

  logic [0:0]  c_in_valid, c_in_last, c_in_ready;
  logic [15:0] c_in_data;
  logic        c_out_valid, c_out_last, c_out_ready;
  logic [15:0] c_out_data;
  logic [0:0]  c_out_ch;

  rr_stream_mux #(.N_CH(4), .WIDTH(8), .LOCK_PKT(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_last(a_in_last), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_last(a_out_last), .out_ready(a_out_ready),
    .out_ch(a_out_ch));

  rr_stream_mux #(.N_CH(4), .WIDTH(8), .LOCK_PKT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_last(b_out_last), .out_ready(b_out_ready),
    .out_ch(b_out_ch));

  rr_stream_mux #(.N_CH(1), .WIDTH(16), .LOCK_PKT(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_last(c_in_last), .in_ready(c_in_ready), .out_valid(c_out_valid),
    .out_data(c_out_data), .out_last(c_out_last), .out_ready(c_out_ready),
    .out_ch(c_out_ch));

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] pk(input int ch, input int data, input bit last);
    return {8'(ch), 16'(data), 7'd0, last};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) check("a_extra_beat", 32'(qa.size()), 32'd1);
          else check("a_beat", pk(a_out_ch, a_out_data, a_out_last), qa.pop_front());
        end
        if (b_out_valid && b_out_ready) begin
          if (qb.size() == 0) check("b_extra_beat", 32'(qb.size()), 32'd1);
          else check("b_beat", pk(b_out_ch, b_out_data, b_out_last), qb.pop_front());
        end
        if (c_out_valid && c_out_ready) begin
          if (qc.size() == 0) check("c_extra_beat", 32'(qc.size()), 32'd1);
          else check("c_beat", pk(c_out_ch, c_out_data, c_out_last), qc.pop_front());
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c_vals [2];
    int k;
    int cyc;
    logic xfer;

    a_in_valid = '0; a_in_last = '0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = '0; c_in_last = '0; c_in_data = '0; c_out_ready = 1'b1;
    fork
      monitor();
    join_none

    #12;
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_ch",    a_out_ch,    0);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_c_valid", c_out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Per-beat fairness: all channels valid, every beat last.
    a_in_data  = 32'h1312_1110;
    a_in_last  = 4'hF;
    a_in_valid = 4'hF;
    for (int i = 0; i < 8; i++) qa.push_back(pk(i % 4, 8'h10 + (i % 4), 1'b1));
    #1 check("a_first_grant", a_in_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("a_fair_valid", a_out_valid, 1);
    end

    // Sparse requests: ch3 alone wraps ptr to 0, then ch0 beats ch3.
    a_in_valid = 4'b1000;
    qa.push_back(pk(3, 8'h13, 1'b1));
    #1 check("a_sparse_ch3", a_in_ready, 4'b1000);
    @(posedge clk); #1;
    a_in_valid = 4'b1001;
    qa.push_back(pk(0, 8'h10, 1'b1));
    #1 check("a_sparse_ch0_wins", a_in_ready, 4'b0001);
    @(posedge clk); #1;
    a_in_valid = 4'b0000;
    @(posedge clk); #1;
    check("a_drain_valid", a_out_valid, 0);
    check("a_drain_hold",  a_out_data,  8'h10);

    // Backpressure: ptr is now 1, so ch1 then ch2.
    a_in_valid = 4'hF;
    qa.push_back(pk(1, 8'h11, 1'b1));
    qa.push_back(pk(2, 8'h12, 1'b1));
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("a_bp_ready", a_in_ready, 4'b0000);
      check("a_bp_data",  a_out_data, 8'h11);
      check("a_bp_ch",    a_out_ch,   1);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    #1 check("a_bp_release_ready", a_in_ready, 4'b0100);
    @(posedge clk); #1;
    a_in_valid = 4'b0000;
    check("a_bp_no_bubble", pk(a_out_ch, a_out_data, a_out_valid), pk(2, 8'h12, 1'b1));
    @(posedge clk); #1;

    // Packet lock: ch1 three beats with a gap, ch2 waiting.
    b_in_valid = 4'b0110;
    b_in_last  = 4'b0100;
    b_in_data  = {8'h00, 8'hB0, 8'hA1, 8'h00};
    qb.push_back(pk(1, 8'hA1, 1'b0));
    #1 check("b_pkt_beat1", b_in_ready, 4'b0010);
    @(posedge clk); #1;
    b_in_data = {8'h00, 8'hB0, 8'hA2, 8'h00};
    qb.push_back(pk(1, 8'hA2, 1'b0));
    #1 check("b_pkt_beat2", b_in_ready, 4'b0010);
    @(posedge clk); #1;
    b_in_valid = 4'b0100;
    #1 check("b_lock_hold_ready", b_in_ready, 4'b0010);
    @(posedge clk); #1;
    check("b_bubble", b_out_valid, 0);
    b_in_valid = 4'b0110;
    b_in_last  = 4'b0110;
    b_in_data  = {8'h00, 8'hB0, 8'hA3, 8'h00};
    qb.push_back(pk(1, 8'hA3, 1'b1));
    #1 check("b_pkt_beat3", b_in_ready, 4'b0010);
    @(posedge clk); #1;
    b_in_data = {8'h00, 8'hB0, 8'hA9, 8'h00};
    qb.push_back(pk(2, 8'hB0, 1'b1));
    #1 check("b_ptr_after_pkt", b_in_ready, 4'b0100);
    @(posedge clk); #1;
    b_in_valid = 4'b0000;
    @(posedge clk); #1;

    // Single channel: order preserved under toggling out_ready.
    c_vals[0] = 16'hBEEF;
    c_vals[1] = 16'hCAFE;
    qc.push_back(pk(0, 16'hBEEF, 1'b0));
    qc.push_back(pk(0, 16'hCAFE, 1'b1));
    k = 0;
    cyc = 0;
    while (k < 2 && cyc < 20) begin
      c_out_ready = cyc[0];
      c_in_valid  = 1'b1;
      c_in_data   = c_vals[k];
      c_in_last   = (k == 1);
      #1 xfer = c_in_ready[0];
      @(posedge clk); #1;
      if (xfer) k++;
      cyc++;
    end
    check("c_stream_done", k, 2);
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Async reset with a held, mid-packet beat on ch2.
    b_out_ready = 1'b0;
    b_in_valid  = 4'b0100;
    b_in_last   = 4'b0000;
    b_in_data   = {8'h00, 8'hC5, 8'h00, 8'h00};
    @(posedge clk); #1;
    b_in_valid = 4'b0000;
    #1;
    check("b_pre_rst_held", pk(b_out_ch, b_out_data, b_out_valid), pk(2, 8'hC5, 1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("b_async_rst_valid", b_out_valid, 0);
    check("b_async_rst_ch",    b_out_ch,    0);
    #1 rst_n = 1'b1;
    b_out_ready = 1'b1;
    b_in_last   = 4'hF;
    b_in_valid  = 4'hF;
    #1 check("b_post_rst_grant", b_in_ready, 4'b0001);
    b_in_valid = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    check("a_queue_empty", 32'(qa.size()), 0);
    check("b_queue_empty", 32'(qb.size()), 0);
    check("c_queue_empty", 32'(qc.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
